// File: rtl/led_strip_driver_if.sv
// Host-side bus of the LED strip driver: byte writes into the back bank,
// frame start with its latched settings, and the busy/done status.
interface led_strip_driver_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DIV_WIDTH  = 8
);
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [7:0]            wr_data;
   logic                  start;
   logic [4:0]            brightness;
   logic [DIV_WIDTH-1:0]  div;
   logic                  busy;
   logic                  done;

   modport master (
      output wr_en, wr_addr, wr_data, start, brightness, div,
      input  busy, done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, start, brightness, div,
      output busy, done
   );
endinterface

// File: rtl/led_strip_driver.sv
// Double-buffered APA102-style strip driver: host fills the back bank while
// the front bank is serialised as start frame, LED frames and end frame.
module led_strip_driver #(
   parameter int N_LEDS     = 320,
   parameter int ADDR_WIDTH = 10,
   parameter int DIV_WIDTH  = 8
) (
   input  logic               clk_sys,
   input  logic               n_reset,
   led_strip_driver_if.slave  host,
   output logic               sck,
   output logic               sdo
);
   localparam int N_BYTES = 3 * N_LEDS;
   localparam int N_END   = (N_LEDS + 15) / 16;
   localparam int MEM_AW  = $clog2(N_BYTES);
   localparam int LED_W   = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
   localparam int END_W   = (N_END > 1) ? $clog2(N_END) : 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_LED, S_END} state_t;

   state_t               state, state_n;
   logic [2:0]           bit_cnt, bit_n;
   logic [1:0]           byte_cnt, byte_n;
   logic [LED_W-1:0]     led_cnt, led_n;
   logic [END_W-1:0]     end_cnt, end_n;
   logic [DIV_WIDTH-1:0] div_cnt, div_n;
   logic [DIV_WIDTH-1:0] div_l, div_ln;
   logic [4:0]           bri_l, bri_n;
   logic [7:0]           sh, sh_n;
   logic                 sck_n;
   logic                 done_q, done_n;
   logic                 bank_sel, bank_n;

   logic [7:0]           bank0 [N_BYTES];
   logic [7:0]           bank1 [N_BYTES];
   logic [7:0]           rd_data;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [1:0]           col_idx;
   logic                 wr_ok;
   logic [MEM_AW-1:0]    wr_idx, rd_idx;
   logic [7:0]           header;

   assign header = {3'b111, bri_l};
   assign sdo    = sh[7];
   assign host.busy = (state != S_IDLE);
   assign host.done = done_q;

   // Address of the colour byte that follows the one currently shifting, so
   // the synchronous read has the whole current byte to settle.
   assign col_idx = (byte_cnt == 2'd3) ? 2'd0 : byte_cnt;
   assign rd_addr = ADDR_WIDTH'(led_cnt) * ADDR_WIDTH'(3) + ADDR_WIDTH'(col_idx);
   assign rd_idx  = MEM_AW'(rd_addr);

   assign wr_ok  = host.wr_en && ({1'b0, host.wr_addr} < (ADDR_WIDTH + 1)'(N_BYTES));
   assign wr_idx = MEM_AW'(host.wr_addr);

   always_ff @(posedge clk_sys) begin
      if (wr_ok) begin
         if (bank_sel) bank0[wr_idx] <= host.wr_data;
         else          bank1[wr_idx] <= host.wr_data;
      end
      rd_data <= bank_sel ? bank1[rd_idx] : bank0[rd_idx];
   end

   always_ff @(posedge clk_sys or negedge n_reset) begin
      if (!n_reset) begin
         state    <= S_IDLE;
         bit_cnt  <= '0;
         byte_cnt <= '0;
         led_cnt  <= '0;
         end_cnt  <= '0;
         div_cnt  <= '0;
         div_l    <= '0;
         bri_l    <= '0;
         sh       <= '0;
         sck      <= 1'b0;
         done_q   <= 1'b0;
         bank_sel <= 1'b0;
      end else begin
         state    <= state_n;
         bit_cnt  <= bit_n;
         byte_cnt <= byte_n;
         led_cnt  <= led_n;
         end_cnt  <= end_n;
         div_cnt  <= div_n;
         div_l    <= div_ln;
         bri_l    <= bri_n;
         sh       <= sh_n;
         sck      <= sck_n;
         done_q   <= done_n;
         bank_sel <= bank_n;
      end
   end

   always_comb begin
      state_n = state;
      bit_n   = bit_cnt;
      byte_n  = byte_cnt;
      led_n   = led_cnt;
      end_n   = end_cnt;
      div_n   = div_cnt;
      div_ln  = div_l;
      bri_n   = bri_l;
      sh_n    = sh;
      sck_n   = sck;
      done_n  = 1'b0;
      bank_n  = bank_sel;

      if (state == S_IDLE) begin
         if (host.start) begin
            bank_n  = ~bank_sel;
            div_ln  = host.div;
            bri_n   = host.brightness;
            state_n = S_START;
            bit_n   = '0;
            byte_n  = '0;
            led_n   = '0;
            end_n   = '0;
            div_n   = '0;
            sck_n   = 1'b0;
            sh_n    = '0;
         end
      end else if (div_cnt != div_l) begin
         div_n = div_cnt + 1'b1;
      end else begin
         div_n = '0;
         if (!sck) begin
            sck_n = 1'b1;
         end else begin
            sck_n = 1'b0;
            if (bit_cnt != 3'd7) begin
               bit_n = bit_cnt + 3'd1;
               sh_n  = {sh[6:0], 1'b0};
            end else begin
               bit_n = '0;
               case (state)
                  S_START: begin
                     if (byte_cnt != 2'd3) begin
                        byte_n = byte_cnt + 2'd1;
                        sh_n   = '0;
                     end else begin
                        state_n = S_LED;
                        byte_n  = '0;
                        led_n   = '0;
                        sh_n    = header;
                     end
                  end
                  S_LED: begin
                     if (byte_cnt != 2'd3) begin
                        byte_n = byte_cnt + 2'd1;
                        sh_n   = rd_data;
                     end else if (led_cnt != LED_W'(N_LEDS - 1)) begin
                        byte_n = '0;
                        led_n  = led_cnt + 1'b1;
                        sh_n   = header;
                     end else begin
                        byte_n  = '0;
                        state_n = S_END;
                        end_n   = '0;
                        sh_n    = 8'hFF;
                     end
                  end
                  S_END: begin
                     if (end_cnt != END_W'(N_END - 1)) begin
                        end_n = end_cnt + 1'b1;
                        sh_n  = 8'hFF;
                     end else begin
                        state_n = S_IDLE;
                        end_n   = '0;
                        sh_n    = '0;
                        done_n  = 1'b1;
                     end
                  end
                  default: state_n = S_IDLE;
               endcase
            end
         end
      end
   end
endmodule
